// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM/WB pipeline register with N-way writeback source
// select, load-data sign/zero extension, register-file write enable
// generation and a free-running retired-instruction counter.
module wb_select_stage #(
  parameter int DATA_W   = 64,
  parameter int NSRC     = 4,
  parameter int SEL_W    = 2,
  parameter int LOAD_SEL = 1,
  parameter int RADDR_W  = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_stall,
  input  logic                     in_flush,
  input  logic [NSRC*DATA_W-1:0]   in_src,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [RADDR_W-1:0]       in_rd,
  input  logic                     in_regwrite,
  input  logic [1:0]               in_ld_size,
  input  logic                     in_ld_signed,
  output logic                     wb_valid,
  output logic [DATA_W-1:0]        wb_data,
  output logic [RADDR_W-1:0]       wb_rd,
  output logic                     wb_we,
  output logic [31:0]              retire_cnt
);

  logic              sel_ok;
  logic              is_load;
  logic [DATA_W-1:0] raw_data;
  logic [DATA_W-1:0] field_mask;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] next_data;
  logic              sign_bit;
  logic              next_we;
  int                field_w;

  // Select indices at or above NSRC are treated as invalid sources.
  assign sel_ok  = ({1'b0, in_sel} < (SEL_W+1)'(NSRC));
  assign is_load = (in_sel == SEL_W'(LOAD_SEL));

  // Pick the selected source slice; an out-of-range select yields zero.
  always_comb begin
    raw_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        raw_data = in_src[k*DATA_W +: DATA_W];
      end
    end
  end

  // Extend the loaded field to full width; on a 32-bit datapath the word
  // and dword sizes collapse to the same full-width field.
  always_comb begin
    case (in_ld_size)
      2'd0:    field_w = 8;
      2'd1:    field_w = 16;
      2'd2:    field_w = (DATA_W > 32) ? 32 : DATA_W;
      default: field_w = DATA_W;
    endcase
    field_mask = {DATA_W{1'b1}} >> (DATA_W - field_w);
    sign_bit   = in_ld_signed & (|(raw_data & field_mask & ~(field_mask >> 1)));
    ext_data   = (raw_data & field_mask) | ({DATA_W{sign_bit}} & ~field_mask);
  end

  // Final writeback value and write enable for the instruction in MEM.
  always_comb begin
    next_data = '0;
    if (sel_ok) begin
      next_data = is_load ? ext_data : raw_data;
    end
    next_we = in_valid & in_regwrite & (in_rd != RADDR_W'(ZERO_REG)) & sel_ok;
  end

  // WB register: flush kills the slot, stall holds it, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      retire_cnt <= 32'd0;
    end else if (in_flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!in_stall) begin
      wb_valid <= in_valid;
      wb_data  <= next_data;
      wb_rd    <= in_rd;
      wb_we    <= next_we;
      if (in_valid) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed cases plus randomized
// traffic, with a queue-based scoreboard fed by a behavioural model.
module tb_wb_select_stage;

  localparam int DATA_W   = 64;
  localparam int NSRC     = 3;
  localparam int SEL_W    = 2;
  localparam int LOAD_SEL = 1;
  localparam int RADDR_W  = 5;
  localparam int ZERO_REG = 31;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_stall;
  logic                   in_flush;
  logic [NSRC*DATA_W-1:0] in_src;
  logic [SEL_W-1:0]       in_sel;
  logic [RADDR_W-1:0]     in_rd;
  logic                   in_regwrite;
  logic [1:0]             in_ld_size;
  logic                   in_ld_signed;
  logic                   wb_valid;
  logic [DATA_W-1:0]      wb_data;
  logic [RADDR_W-1:0]     wb_rd;
  logic                   wb_we;
  logic [31:0]            retire_cnt;

  logic [63:0] src_arr [NSRC];

  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic        m_valid;
  logic [63:0] m_data;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_cnt;

  int checks;
  int failures;

  wb_select_stage #(
    .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .LOAD_SEL(LOAD_SEL),
    .RADDR_W(RADDR_W), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stall(in_stall),
    .in_flush(in_flush), .in_src(in_src), .in_sel(in_sel), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_ld_size(in_ld_size),
    .in_ld_signed(in_ld_signed), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .retire_cnt(retire_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack the per-source array into the flat source bus.
  always_comb begin
    for (int k = 0; k < NSRC; k++) begin
      in_src[k*DATA_W +: DATA_W] = src_arr[k];
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected writeback value from the arithmetic definition of extension.
  function automatic logic [63:0] ref_data(input logic [1:0] sel, input logic [1:0] sz, input logic sg);
    logic [63:0] raw;
    logic [63:0] field;
    logic [63:0] span;
    int          bits;
    if (int'(sel) >= NSRC) return 64'd0;
    raw = src_arr[sel];
    if (int'(sel) != LOAD_SEL || sz == 2'd3) return raw;
    bits  = 8 << sz;
    span  = 64'd1 << bits;
    field = raw % span;
    if (sg && field >= (span >> 1)) return field - span;
    return field;
  endfunction

  task automatic modelReset();
    m_valid = 1'b0;
    m_data  = 64'd0;
    m_rd    = 5'd0;
    m_we    = 1'b0;
    m_cnt   = 32'd0;
  endtask

  // Drive one cycle of inputs, predict the post-edge state, queue it.
  task automatic applyStimulus(input logic v, input logic st, input logic fl,
                               input logic [1:0] sel, input logic [4:0] rd,
                               input logic rw, input logic [1:0] sz, input logic sg);
    exp_t e;
    in_valid     = v;
    in_stall     = st;
    in_flush     = fl;
    in_sel       = sel;
    in_rd        = rd;
    in_regwrite  = rw;
    in_ld_size   = sz;
    in_ld_signed = sg;
    if (fl) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
    end else if (!st) begin
      m_valid = v;
      m_data  = ref_data(sel, sz, sg);
      m_rd    = rd;
      m_we    = v && rw && (int'(rd) != ZERO_REG) && (int'(sel) < NSRC);
      if (v) m_cnt = m_cnt + 32'd1;
    end
    e = '{m_valid, m_data, m_rd, m_we, m_cnt};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: after each rising edge compare DUT state with the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_valid", {63'd0, wb_valid}, {63'd0, e.valid});
        checkOutput("sb_data", wb_data, e.data);
        checkOutput("sb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
        checkOutput("sb_we", {63'd0, wb_we}, {63'd0, e.we});
        checkOutput("sb_cnt", {32'd0, retire_cnt}, {32'd0, e.cnt});
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, wb_valid}, 64'd0);
    checkOutput({tag, "_we"}, {63'd0, wb_we}, 64'd0);
    checkOutput({tag, "_data"}, wb_data, 64'd0);
    checkOutput({tag, "_rd"}, {59'd0, wb_rd}, 64'd0);
    checkOutput({tag, "_cnt"}, {32'd0, retire_cnt}, 64'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_stall     = 1'b0;
    in_flush     = 1'b0;
    in_sel       = 2'd0;
    in_rd        = 5'd0;
    in_regwrite  = 1'b0;
    in_ld_size   = 2'd0;
    in_ld_signed = 1'b0;
    for (int k = 0; k < NSRC; k++) src_arr[k] = 64'd0;
    modelReset();

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Basic select
    src_arr[0] = 64'd10;
    src_arr[1] = 64'd20;
    src_arr[2] = 64'd30;
    applyStimulus(1, 0, 0, 2'd2, 5'd3, 1, 2'd0, 0);
    checkOutput("basic_data", wb_data, 64'd30);
    checkOutput("basic_rd", {59'd0, wb_rd}, 64'd3);
    checkOutput("basic_we", {63'd0, wb_we}, 64'd1);
    checkOutput("basic_cnt", {32'd0, retire_cnt}, 64'd1);

    // Load extension
    src_arr[0] = 64'h8F80;
    src_arr[1] = 64'h8F80;
    applyStimulus(1, 0, 0, 2'd1, 5'd5, 1, 2'd0, 1);
    checkOutput("ld_b_signed", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1, 0, 0, 2'd1, 5'd5, 1, 2'd0, 0);
    checkOutput("ld_b_unsigned", wb_data, 64'h80);
    applyStimulus(1, 0, 0, 2'd1, 5'd5, 1, 2'd1, 1);
    checkOutput("ld_h_signed", wb_data, 64'hFFFF_FFFF_FFFF_8F80);
    applyStimulus(1, 0, 0, 2'd1, 5'd5, 1, 2'd3, 1);
    checkOutput("ld_d", wb_data, 64'h8F80);
    applyStimulus(1, 0, 0, 2'd1, 5'd5, 1, 2'd2, 1);
    checkOutput("ld_w_signed", wb_data, 64'h8F80);
    applyStimulus(1, 0, 0, 2'd0, 5'd5, 1, 2'd0, 1);
    checkOutput("nonload_pass", wb_data, 64'h8F80);

    // Zero register and bad select
    applyStimulus(1, 0, 0, 2'd2, 5'd31, 1, 2'd0, 0);
    checkOutput("xzr_we", {63'd0, wb_we}, 64'd0);
    checkOutput("xzr_valid", {63'd0, wb_valid}, 64'd1);
    applyStimulus(1, 0, 0, 2'd3, 5'd4, 1, 2'd0, 0);
    checkOutput("badsel_data", wb_data, 64'd0);
    checkOutput("badsel_we", {63'd0, wb_we}, 64'd0);

    // Stall hold then stall+flush
    src_arr[2] = 64'hAAAA;
    applyStimulus(1, 0, 0, 2'd2, 5'd7, 1, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NSRC; k++) src_arr[k] = {$urandom, $urandom};
      applyStimulus(1, 1, 0, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 30)), 1, 2'd0, 0);
    end
    checkOutput("stall_data", wb_data, 64'hAAAA);
    checkOutput("stall_rd", {59'd0, wb_rd}, 64'd7);
    checkOutput("stall_we", {63'd0, wb_we}, 64'd1);
    checkOutput("stall_cnt", {32'd0, retire_cnt}, 64'd10);
    applyStimulus(1, 1, 1, 2'd2, 5'd9, 1, 2'd0, 0);
    checkOutput("flush_valid", {63'd0, wb_valid}, 64'd0);
    checkOutput("flush_we", {63'd0, wb_we}, 64'd0);
    checkOutput("flush_cnt", {32'd0, retire_cnt}, 64'd10);
    checkOutput("flush_data", wb_data, 64'hAAAA);

    // Async reset between edges while a stalled valid instruction is presented
    applyStimulus(1, 0, 0, 2'd2, 5'd7, 1, 2'd0, 0);
    in_stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    @(negedge clk);
    @(negedge clk);
    checkAllZero("rst_hold");
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1, 0, 0, 2'd2, 5'd8, 1, 2'd0, 0);
    checkOutput("post_rst_cnt", {32'd0, retire_cnt}, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NSRC; k++) src_arr[k] = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 9) == 0),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom),
                    1'($urandom_range(0, 3) != 0),
                    2'($urandom),
                    1'($urandom));
    end

    @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
